// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, data width and line levels.
// Used by the transmitter today and the matching receiver later.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE      = 1'b1;
    localparam logic UART_START     = 1'b0;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period down-counter; o_bit_end marks the last clock of a bit.
// Holds at zero when not reloaded, so an idle link sees o_bit_end high.
module uart_baud_cnt #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_load_val,
    output logic             o_bit_end
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_bit_end = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, 1 or 2 stops.
// Frame settings are captured on accept; o_tx is registered for a clean pad drive.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_parity_en,
    input  logic             i_parity_odd,
    input  logic             i_two_stop,
    input  logic [7:0]       i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_tx,
    output logic             o_busy
);

    uart_state_e      state_q, state_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             stop_idx_q, stop_idx_d;
    logic [7:0]       data_q, data_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             par_en_q, par_en_d;
    logic             par_odd_q, par_odd_d;
    logic             two_stop_q, two_stop_d;
    logic             tx_q, tx_d;

    logic             bit_end;
    logic             last_stop;
    logic             accept;
    logic             cnt_load;
    logic [DIV_W-1:0] cnt_load_val;

    assign last_stop = (state_q == STOP) && bit_end && (!two_stop_q || stop_idx_q);
    assign accept    = i_valid && o_ready;

    // Reload at every bit boundary except the frame's end; an accept there restarts it.
    assign cnt_load     = accept || (bit_end && (state_q != IDLE) && !last_stop);
    assign cnt_load_val = accept ? i_div : div_q;

    uart_baud_cnt #(
        .DIV_W (DIV_W)
    ) u_baud_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (cnt_load),
        .i_load_val (cnt_load_val),
        .o_bit_end  (bit_end)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            data_q     <= '0;
            div_q      <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= UART_IDLE;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            data_q     <= data_d;
            div_q      <= div_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        data_d     = data_q;
        div_d      = div_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;

        if (accept) begin
            data_d     = i_data;
            div_d      = i_div;
            par_en_d   = i_parity_en;
            par_odd_d  = i_parity_odd;
            two_stop_d = i_two_stop;
        end

        case (state_q)
            IDLE: begin
                if (accept) state_d = START;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
                        state_d    = par_en_q ? PARITY : STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                end
            end
            STOP: begin
                if (last_stop) begin
                    state_d = accept ? START : IDLE;
                end else if (bit_end) begin
                    stop_idx_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is derived from the next state so it lands with the state change.
    always_comb begin
        tx_d = UART_IDLE;
        case (state_d)
            START:   tx_d = UART_START;
            DATA:    tx_d = data_q[bit_idx_d];
            PARITY:  tx_d = (^data_q) ^ par_odd_q;
            default: tx_d = UART_IDLE;
        endcase
        o_ready = i_rst_n && ((state_q == IDLE) || last_stop);
        o_busy  = (state_q != IDLE);
        o_tx    = tx_q;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset, framing, parity, stop bits, back-to-back,
// mid-frame input changes and mid-frame reset.
module tb_uart_tx;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [15:0] i_div;
    logic        i_parity_en;
    logic        i_parity_odd;
    logic        i_two_stop;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        o_ready;
    logic        o_tx;
    logic        o_busy;

    int n_chk  = 0;
    int n_fail = 0;

    uart_tx #(.DIV_W(16)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_div        (i_div),
        .i_parity_en  (i_parity_en),
        .i_parity_odd (i_parity_odd),
        .i_two_stop   (i_two_stop),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_tx         (o_tx),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Present a byte and wait (bounded) for the accept edge; leaves us #1 after it.
    task automatic send(input logic [7:0] d, input int div, input bit pe, input bit po,
                        input bit ts, input bit hold);
        int n;
        i_data = d; i_div = div[15:0]; i_parity_en = pe; i_parity_odd = po;
        i_two_stop = ts; i_valid = 1'b1;
        n = 0;
        #1;
        while (!o_ready && n < 200) begin
            tick();
            n++;
        end
        if (!o_ready) chk("accept_timeout", 32'(o_ready), 32'd1);
        tick();
        if (!hold) i_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; checks every clock of the frame, ending in its last clock.
    task automatic check_frame(input string tag, input logic [7:0] d, input int div,
                               input bit pe, input bit par, input bit ts);
        int  nbits;
        bit  eb;
        bit  last;
        nbits = 10 + int'(pe) + int'(ts);
        for (int b = 0; b < nbits; b++) begin
            if (b == 0)               eb = 1'b0;
            else if (b <= 8)          eb = d[b-1];
            else if (b == 9 && pe)    eb = par;
            else                      eb = 1'b1;
            for (int c = 0; c <= div; c++) begin
                last = (b == nbits - 1) && (c == div);
                chk($sformatf("%s_tx_b%0d_c%0d", tag, b, c), 32'(o_tx), 32'(eb));
                chk($sformatf("%s_rdy_b%0d_c%0d", tag, b, c), 32'(o_ready), 32'(last));
                chk($sformatf("%s_busy_b%0d", tag, b), 32'(o_busy), 32'd1);
                if (!last) tick();
            end
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_idle_tx"},   32'(o_tx),    32'd1);
        chk({tag, "_idle_busy"}, 32'(o_busy),  32'd0);
        chk({tag, "_idle_rdy"},  32'(o_ready), 32'd1);
    endtask

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b1; i_data = 8'h55; i_div = 16'd3;
        i_parity_en = 1'b0; i_parity_odd = 1'b0; i_two_stop = 1'b0;

        // Reset with valid held high
        repeat (3) tick();
        chk("rst_tx",   32'(o_tx),    32'd1);
        chk("rst_rdy",  32'(o_ready), 32'd0);
        chk("rst_busy", 32'(o_busy),  32'd0);
        i_rst_n = 1'b1;
        #1;
        chk("rel_rdy", 32'(o_ready), 32'd1);
        i_valid = 1'b0;
        tick();
        check_idle("rel");

        // 0x55, div=3, no parity, one stop: 40 clocks
        send(8'h55, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame("f55", 8'h55, 3, 1'b0, 1'b0, 1'b0);
        tick();
        check_idle("f55");
        repeat (2) tick();
        chk("f55_hold_tx", 32'(o_tx), 32'd1);

        // Parity at div=0
        send(8'h03, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_frame("p03e", 8'h03, 0, 1'b1, 1'b0, 1'b0);
        tick();
        check_idle("p03e");
        send(8'h03, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_frame("p03o", 8'h03, 0, 1'b1, 1'b1, 1'b0);
        tick();
        check_idle("p03o");
        send(8'h07, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_frame("p07e2", 8'h07, 0, 1'b1, 1'b1, 1'b1);
        tick();
        check_idle("p07e2");

        // Back-to-back, valid held, div=1
        send(8'hA5, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        i_data = 8'h3C;
        check_frame("bbA5", 8'hA5, 1, 1'b0, 1'b0, 1'b0);
        tick();
        i_valid = 1'b0;
        check_frame("bb3C", 8'h3C, 1, 1'b0, 1'b0, 1'b0);
        tick();
        check_idle("bb");

        // Inputs change after accept; frame keeps captured settings
        send(8'h5A, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        i_div = 16'd0; i_data = 8'hFF; i_parity_en = 1'b1; i_two_stop = 1'b1;
        i_parity_odd = 1'b1;
        check_frame("mid", 8'h5A, 2, 1'b0, 1'b0, 1'b0);
        tick();
        check_idle("mid");

        // Reset mid-DATA, then a fresh frame
        send(8'h00, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) tick();
        chk("abort_pre_tx",   32'(o_tx),   32'd0);
        chk("abort_pre_busy", 32'(o_busy), 32'd1);
        i_rst_n = 1'b0;
        tick();
        chk("abort_tx",   32'(o_tx),    32'd1);
        chk("abort_busy", 32'(o_busy),  32'd0);
        chk("abort_rdy",  32'(o_ready), 32'd0);
        i_rst_n = 1'b1;
        repeat (3) tick();
        check_idle("abort");
        send(8'hF0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_frame("fresh", 8'hF0, 1, 1'b1, 1'b0, 1'b0);
        tick();
        check_idle("fresh");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that serialises bytes into asynchronous 8-bit UART frames. It is the stage directly upstream of the SoC output pad wrapper: `o_tx` drives the pad's `i_pad_out`. A peripheral register block feeds it bytes over a valid/ready handshake, and the baud rate is set at run time by a clock divisor.

## Interface
Parameters:
- `DIV_W`, default 16: width of the baud divisor input.

Ports:
- `i_clk`  in  1  single system clock; all logic on rising edge
- `i_rst_n`  in  1  reset, synchronous, active-low
- `i_div`  in  DIV_W  bit period in clocks minus 1 (bit period = `i_div`+1); latched at accept
- `i_parity_en`  in  1  append parity bit; latched at accept
- `i_parity_odd`  in  1  1 = odd parity, 0 = even; latched at accept
- `i_two_stop`  in  1  1 = two stop bits, 0 = one; latched at accept
- `i_data`  in  8  byte to send
- `i_valid`  in  1  `i_data` is valid
- `o_ready`  out  1  block can accept a byte this cycle
- `o_tx`  out  1  serial line to the output pad; idle high
- `o_busy`  out  1  frame in progress

## Operation
- Frame format, in order:
  - start bit (0)
  - 8 data bits, LSB first
  - optional parity bit
  - 1 or 2 stop bits (1)
- Even parity = XOR of the 8 data bits; odd parity = its inverse.
- The FSM has five states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept (`i_valid` & `o_ready`).
  - START -> DATA after one bit period.
  - DATA -> PARITY when `i_parity_en`, else -> STOP, after 8 bit periods; a 3-bit index counts the data bits.
  - PARITY -> STOP after one bit period.
  - STOP -> IDLE after 1 or 2 bit periods, unless a new byte is accepted (see below).
- On accept, the block latches `i_data`, `i_div`, `i_parity_en`, `i_parity_odd` and `i_two_stop`. Changes to these inputs mid-frame have no effect on the current frame.
- Bit timing uses a down-counter of DIV_W bits.
  - It is loaded with the latched divisor at each bit start.
  - The bit ends on the cycle the counter reads 0.
  - `i_div`=0 gives one clock per bit.
- `o_ready` is asserted in IDLE and in the last clock of the final stop bit. An accept in that last stop-bit clock goes directly to START, giving back-to-back frames with no extra idle cycle.
- `o_busy` is 1 in every state except IDLE.
- `o_tx` is a registered output with no combinational path from inputs, so it is glitch-free toward the pad.
- `i_valid` without `o_ready` is ignored. Data need not be held after the accept cycle.

## Timing
- Reset (`i_rst_n`=0 at a rising edge):
  - next state: IDLE, `o_tx`=1, `o_busy`=0
  - `o_ready` is forced 0 while `i_rst_n`=0
- Reset mid-frame aborts the frame. The line returns high on the reset edge and the partial frame is never resumed.
- Accept at edge k: `o_tx`=0 from cycle k+1 for `i_div`+1 cycles.
- Frame length in clocks = (`i_div`+1) × (1 + 8 + `i_parity_en` + 1 + `i_two_stop`).
- After the last stop bit, with no new accept, the line stays 1 and `o_ready`=1 until the next accept.
- `o_ready` is combinational from state and counters only, never from `i_valid`.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP)
  - `UART_DATA_BITS`=8
  - line levels `UART_IDLE`=1'b1 and `UART_START`=1'b0
- A sub-module is natural: `uart_baud_cnt` (loadable down-counter with a `o_bit_end` strobe), reused later by the matching receiver.
- Everything else lives in `uart_tx`.

## Test plan
- Reset with `i_valid`=1 held:
  - during reset: `o_tx`=1, `o_ready`=0, `o_busy`=0
  - first cycle after release: `o_ready`=1
- `i_div`=3, 1 stop, no parity, send 0x55:
  - `o_tx` = 0, then 1,0,1,0,1,0,1,0, then 1, each for 4 clocks
  - frame = 40 clocks; `o_ready` high on clock 40
- `i_div`=0, parity enabled:
  - 0x03 even parity -> parity bit 0; odd parity -> 1
  - 0x07 even parity -> parity bit 1
  - two stop bits -> 12-clock frame
- Back-to-back 0xA5 then 0x3C with `i_valid` held high, `i_div`=1:
  - the second start bit begins the cycle after the first stop bit ends
  - no extra idle clock; total 40 clocks
- Change `i_div` and `i_data` mid-frame -> the current frame keeps the original divisor and data bits.
- Assert `i_rst_n`=0 mid-DATA -> `o_tx`=1 on the next edge; after release, a new byte sends a complete fresh frame.
